// File: rtl/simplez_ctrl.sv
// rtl/simplez_ctrl.sv - Simplez CPU control sequencer (optional single-step via SIMPLEZ_STEP_EN)
module simplez_ctrl (
  input  logic       clk,
  input  logic       rstn,
  input  logic [2:0] opcode,
  input  logic       zero,
`ifdef SIMPLEZ_STEP_EN
  input  logic       step,
`endif
  output logic       maddr_sel,
  output logic       ri_load,
  output logic       pc_inc,
  output logic       pc_load,
  output logic       a_load,
  output logic [1:0] alu_op,
  output logic       mem_we,
  output logic       halt,
  output logic [2:0] state
);

  localparam logic [2:0] S_INIT   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_LOADRI = 3'd2;
  localparam logic [2:0] S_DECODE = 3'd3;
  localparam logic [2:0] S_EXEC   = 3'd4;
  localparam logic [2:0] S_HALTED = 3'd5;

  localparam logic [2:0] OP_ST   = 3'd0;
  localparam logic [2:0] OP_LD   = 3'd1;
  localparam logic [2:0] OP_ADD  = 3'd2;
  localparam logic [2:0] OP_BR   = 3'd3;
  localparam logic [2:0] OP_BZ   = 3'd4;
  localparam logic [2:0] OP_CLR  = 3'd5;
  localparam logic [2:0] OP_DEC  = 3'd6;
  localparam logic [2:0] OP_HALT = 3'd7;

  localparam logic [1:0] ALU_PASS = 2'b00;
  localparam logic [1:0] ALU_ADD  = 2'b01;
  localparam logic [1:0] ALU_DEC  = 2'b10;
  localparam logic [1:0] ALU_ZERO = 2'b11;

  logic [2:0] state_r;
  logic [2:0] state_nxt;
  logic       fetch_go;

`ifdef SIMPLEZ_STEP_EN
  logic step_q;

  // Remember last step level so a held-high step releases only one instruction.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) step_q <= 1'b0;
    else       step_q <= step;
  end

  assign fetch_go = step & ~step_q;
`else
  assign fetch_go = 1'b1;
`endif

  // State register; reset forces INIT from any state, even mid-instruction.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_r <= S_INIT;
    else       state_r <= state_nxt;
  end

  assign state = state_r;

  // Next-state and strobe decode; strobes depend only on state, opcode and zero.
  always_comb begin
    state_nxt = S_INIT;
    maddr_sel = 1'b0;
    ri_load   = 1'b0;
    pc_inc    = 1'b0;
    pc_load   = 1'b0;
    a_load    = 1'b0;
    alu_op    = ALU_PASS;
    mem_we    = 1'b0;
    halt      = 1'b0;
    case (state_r)
      S_INIT: state_nxt = S_FETCH;
      S_FETCH: state_nxt = fetch_go ? S_LOADRI : S_FETCH;
      S_LOADRI: begin
        ri_load   = 1'b1;
        pc_inc    = 1'b1;
        state_nxt = S_DECODE;
      end
      S_DECODE: begin
        maddr_sel = 1'b1;
        state_nxt = S_FETCH;
        case (opcode)
          OP_ST:   mem_we = 1'b1;
          OP_LD:   state_nxt = S_EXEC;
          OP_ADD:  state_nxt = S_EXEC;
          OP_BR:   pc_load = 1'b1;
          OP_BZ:   pc_load = zero;
          OP_CLR: begin
            a_load = 1'b1;
            alu_op = ALU_ZERO;
          end
          OP_DEC: begin
            a_load = 1'b1;
            alu_op = ALU_DEC;
          end
          OP_HALT: state_nxt = S_HALTED;
          default: state_nxt = S_FETCH;
        endcase
      end
      S_EXEC: begin
        // Operand read at CD was issued in DECODE, so RAM data is valid now.
        maddr_sel = 1'b1;
        a_load    = 1'b1;
        alu_op    = (opcode == OP_ADD) ? ALU_ADD : ALU_PASS;
        state_nxt = S_FETCH;
      end
      S_HALTED: begin
        halt      = 1'b1;
        state_nxt = S_HALTED;
      end
      default: state_nxt = S_INIT;
    endcase
  end

endmodule

// File: tb/tb_simplez_ctrl.sv
// tb/tb_simplez_ctrl.sv - self-checking bench for simplez_ctrl with behavioural datapath and ISA model
module tb_simplez_ctrl;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic [2:0] opcode;
  logic       zero;
  logic       maddr_sel, ri_load, pc_inc, pc_load, a_load, mem_we, halt;
  logic [1:0] alu_op;
  logic [2:0] state;
`ifdef SIMPLEZ_STEP_EN
  logic       step = 1'b0;
`endif

  always #5 clk = ~clk;

  simplez_ctrl dut (
    .clk(clk), .rstn(rstn), .opcode(opcode), .zero(zero),
`ifdef SIMPLEZ_STEP_EN
    .step(step),
`endif
    .maddr_sel(maddr_sel), .ri_load(ri_load), .pc_inc(pc_inc), .pc_load(pc_load),
    .a_load(a_load), .alu_op(alu_op), .mem_we(mem_we), .halt(halt), .state(state)
  );

  // Datapath driven by the controller strobes
  logic [11:0] ram [512];
  logic [8:0]  pc;
  logic [11:0] ri, a, rdata;
  logic        ld_en = 1'b0;
  logic [8:0]  ld_addr = '0;
  logic [11:0] ld_data = '0;
  logic [8:0]  maddr;

  assign opcode = ri[11:9];
  assign zero   = (a == 12'd0);
  assign maddr  = maddr_sel ? ri[8:0] : pc;

  always @(posedge clk) begin
    if (ld_en)       ram[ld_addr] <= ld_data;
    else if (mem_we) ram[ri[8:0]] <= a;
    rdata <= ram[maddr];
  end

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pc <= '0; ri <= '0; a <= '0;
    end else begin
      if (pc_inc)       pc <= pc + 9'd1;
      else if (pc_load) pc <= ri[8:0];
      if (ri_load) ri <= rdata;
      if (a_load) begin
        case (alu_op)
          2'b00: a <= rdata;
          2'b01: a <= a + rdata;
          2'b10: a <= a - 12'd1;
          default: a <= 12'd0;
        endcase
      end
    end
  end

  int vectors = 0;
  int miscompares = 0;
  logic [11:0] img [512];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] ins(input logic [2:0] op, input logic [8:0] cd);
    return {op, cd};
  endfunction

  function automatic logic [31:0] all_out();
    return {23'd0, maddr_sel, ri_load, pc_inc, pc_load, a_load, alu_op, mem_we, halt};
  endfunction

  task automatic clear_img();
    for (int i = 0; i < 512; i++) img[i] = 12'd0;
  endtask

  task automatic load_img();
    @(negedge clk);
    rstn = 1'b0;
    for (int i = 0; i < 512; i++) begin
      ld_en = 1'b1; ld_addr = i[8:0]; ld_data = img[i];
      @(negedge clk);
    end
    ld_en = 1'b0;
  endtask

  // ISA-level reference: expected per-cycle state, PC and decode strobes,
  // then final A, PC and RAM.
  task automatic run_prog(input string name);
    logic [11:0] m [512];
    logic [8:0]  pcm, npc, cd;
    logic [11:0] am, w;
    logic [2:0]  op;
    int qs[$], qp[$], qd[$];
    int nbad;
    bit done;
    for (int i = 0; i < 512; i++) m[i] = img[i];
    pcm = '0; am = '0; done = 0;
    for (int n = 0; n < 1000 && !done; n++) begin
      w = m[pcm]; op = w[11:9]; cd = w[8:0];
      npc = pcm + 9'd1;
      qs.push_back(1); qp.push_back(int'(pcm)); qd.push_back(-1);
      qs.push_back(2); qp.push_back(-1);        qd.push_back(-1);
      qs.push_back(3); qp.push_back(int'(npc));
      case (op)
        3'd0: begin qd.push_back(5'b00001); m[cd] = am; end
        3'd1: begin qd.push_back(0); am = m[cd];
                    qs.push_back(4); qp.push_back(-1); qd.push_back(5'b01000); end
        3'd2: begin qd.push_back(0); am = am + m[cd];
                    qs.push_back(4); qp.push_back(-1); qd.push_back(5'b01010); end
        3'd3: begin qd.push_back(5'b10000); npc = cd; end
        3'd4: begin
          qd.push_back(am == 12'd0 ? 5'b10000 : 5'b00000);
          if (am == 12'd0) npc = cd;
        end
        3'd5: begin qd.push_back(5'b01110); am = 12'd0; end
        3'd6: begin qd.push_back(5'b01100); am = am - 12'd1; end
        default: begin qd.push_back(0); done = 1; end
      endcase
      pcm = npc;
    end

    load_img();
    @(negedge clk);
    rstn = 1'b1;
    #1 chk({name, ":release_state"}, state, 0);
    for (int k = 0; k < qs.size(); k++) begin
      @(negedge clk);
      chk({name, ":state"}, state, qs[k]);
      if (qp[k] >= 0) chk({name, ":pc"}, pc, qp[k]);
      if (qd[k] >= 0) chk({name, ":strobes"}, {pc_load, a_load, alu_op, mem_we}, qd[k]);
      chk({name, ":pc_excl"}, pc_inc & pc_load, 0);
`ifdef SIMPLEZ_STEP_EN
      step = (state == 3'd1);
`endif
    end
`ifdef SIMPLEZ_STEP_EN
    step = 1'b0;
`endif
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk({name, ":halted_state"}, state, 5);
      chk({name, ":halted_out"}, all_out(), 1);
    end
    chk({name, ":acc"}, a, am);
    chk({name, ":final_pc"}, pc, pcm);
    nbad = 0;
    for (int i = 0; i < 512; i++) if (ram[i] !== m[i]) nbad++;
    chk({name, ":ram_words_bad"}, nbad, 0);
  endtask

  initial begin
    bit found;
    int tgt;
    // Program LD 10 / ADD 11 / ST 12 / HALT
    clear_img();
    img[0] = ins(3'd1, 9'd10); img[1] = ins(3'd2, 9'd11);
    img[2] = ins(3'd0, 9'd12); img[3] = ins(3'd7, 9'd0);
    img[10] = 12'd5; img[11] = 12'd7;
    load_img();
    #1 chk("reset_outputs", all_out(), 0);
    chk("reset_state", state, 0);
    run_prog("ld_add_st");
    chk("st_result", ram[12], 12);
    chk("halt_pc", pc, 4);

    // Asynchronous reset in the middle of EXEC
    @(negedge clk); rstn = 1'b0;
    @(negedge clk); rstn = 1'b1;
    found = 0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(negedge clk);
      if (state == 3'd4) found = 1;
    end
    chk("exec_reached", found, 1);
    #2 rstn = 1'b0;
    #1 chk("midexec_reset_out", all_out(), 0);
    chk("midexec_reset_state", state, 0);
    @(negedge clk); rstn = 1'b1;
    #1 chk("rel_state0", state, 0);
    for (int s = 1; s <= 3; s++) begin
      @(negedge clk);
      chk("rel_state_seq", state, s);
    end

    // BZ taken with A=0
    clear_img();
    img[0] = ins(3'd4, 9'd20); img[20] = ins(3'd7, 9'd0);
    run_prog("bz_taken");

    // BZ not taken with A=3
    clear_img();
    img[0] = ins(3'd1, 9'd30); img[1] = ins(3'd4, 9'd20); img[2] = ins(3'd7, 9'd0);
    img[20] = ins(3'd7, 9'd0); img[30] = 12'd3;
    run_prog("bz_not_taken");

    // CLR then DEC wraps A to 4095
    clear_img();
    img[0] = ins(3'd1, 9'd30); img[1] = ins(3'd5, 9'd0); img[2] = ins(3'd6, 9'd0);
    img[3] = ins(3'd7, 9'd0); img[30] = 12'd9;
    run_prog("clr_dec");
    chk("dec_wrap", a, 4095);

    // PC wrap at 511
    clear_img();
    img[0] = ins(3'd3, 9'd511); img[511] = ins(3'd3, 9'd5); img[5] = ins(3'd7, 9'd0);
    run_prog("pc_wrap");

    // Random forward-branching programs
    for (int p = 0; p < 8; p++) begin
      clear_img();
      for (int i = 0; i < 15; i++) begin
        logic [2:0] op;
        op = 3'($urandom_range(0, 6));
        if (op == 3'd3 || op == 3'd4) begin
          tgt = $urandom_range(i + 1, 15);
          img[i] = ins(op, 9'(tgt));
        end else begin
          img[i] = ins(op, 9'(100 + $urandom_range(0, 15)));
        end
      end
      img[15] = ins(3'd7, 9'd0);
      for (int i = 100; i < 116; i++) img[i] = 12'($urandom);
      run_prog($sformatf("rand%0d", p));
    end

`ifdef SIMPLEZ_STEP_EN
    clear_img();
    img[0] = ins(3'd5, 9'd0); img[1] = ins(3'd5, 9'd0); img[2] = ins(3'd7, 9'd0);
    step = 1'b0;
    load_img();
    @(negedge clk); rstn = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk("step_hold_state", state, 1);
      chk("step_hold_out", all_out(), 0);
    end
    step = 1'b1;
    @(negedge clk); step = 1'b0; chk("step_pulse_s2", state, 2);
    @(negedge clk); chk("step_pulse_s3", state, 3);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); chk("step_pulse_back", state, 1);
    end
    chk("step_pulse_pc", pc, 1);
    step = 1'b1;
    @(negedge clk); chk("step_held_s2", state, 2);
    @(negedge clk); chk("step_held_s3", state, 3);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); chk("step_held_back", state, 1);
    end
    chk("step_held_pc", pc, 2);
    step = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
